// File: rtl/ahb_pkg.sv
// AHB encodings, arbiter FSM states and the per-port held transfer header.
// Shared by the master-port arbiter and its round-robin sub-module.
package ahb_pkg;

    localparam logic [1:0] tIDLE   = 2'b00;
    localparam logic [1:0] tBUSY   = 2'b01;
    localparam logic [1:0] tNONSEQ = 2'b10;
    localparam logic [1:0] tSEQ    = 2'b11;

    localparam logic [2:0] tSINGLE = 3'b000;
    localparam logic [2:0] tINCR   = 3'b001;
    localparam logic [2:0] tWRAP4  = 3'b010;
    localparam logic [2:0] tINCR4  = 3'b011;
    localparam logic [2:0] tWRAP8  = 3'b100;
    localparam logic [2:0] tINCR8  = 3'b101;
    localparam logic [2:0] tWRAP16 = 3'b110;
    localparam logic [2:0] tINCR16 = 3'b111;

    localparam logic [1:0] rOKAY  = 2'b00;
    localparam logic [1:0] rERROR = 2'b01;
    localparam logic [1:0] rRETRY = 2'b10;
    localparam logic [1:0] rSPLIT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_RESP = 3'd3,
        S_ERR1 = 3'd4,
        S_ERR2 = 3'd5
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic        lock;
    } hdr_t;

    // Port index width for the supported 2..4 port range.
    function automatic int idx_w(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin pick among pending ports, restricted to the lock owner while a lock is held.
// Latency: combinational grant; pointer advances on the cycle update is strobed.
// Backpressure: none; requests simply stay asserted until granted.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int NPORTS = 2,
    localparam int IW = idx_w(NPORTS)
) (
    input  logic              hclk,
    input  logic              resetn,
    input  logic [NPORTS-1:0] req,
    input  logic              lock_valid,
    input  logic [IW-1:0]     lock_owner,
    input  logic              update,
    output logic [NPORTS-1:0] grant,
    output logic [IW-1:0]     grant_idx
);

    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     cand;
    logic [NPORTS-1:0] eligible;
    logic              found;

    always_comb begin
        eligible  = req;
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        if (lock_valid) begin
            eligible = req & (NPORTS'(1) << lock_owner);
        end
        // Search starts one past the previous winner so every port gets a turn.
        for (int i = 1; i <= NPORTS; i++) begin
            cand = IW'((int'(last_grant) + i) % NPORTS);
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= IW'(NPORTS - 1);
        end else if (update) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB master port among NPORTS requester ports as registered single transfers.
// Latency: accept at T, shared-bus address phase T+2, data T+3, port completion T+4 (zero-wait slave).
// Backpressure: port hready stays low while its transfer is held; shared hready stretches ADDR/DATA.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NPORTS = 2
) (
    input  logic                hclk,
    input  logic                resetn,
    input  logic [NPORTS*32-1:0] ahb_mmst_haddr,
    input  logic [NPORTS*2-1:0] ahb_mmst_htrans,
    input  logic [NPORTS-1:0]   ahb_mmst_hwrite,
    input  logic [NPORTS*3-1:0] ahb_mmst_hsize,
    input  logic [NPORTS*3-1:0] ahb_mmst_hburst,
    input  logic [NPORTS*4-1:0] ahb_mmst_hprot,
    input  logic [NPORTS-1:0]   ahb_mmst_hlock,
    input  logic [NPORTS*32-1:0] ahb_mmst_hwdata,
    output logic [NPORTS*32-1:0] ahb_mmst_hrdata,
    output logic [NPORTS-1:0]   ahb_mmst_hready,
    output logic [NPORTS*2-1:0] ahb_mmst_hresp,
    output logic [31:0]         ahb_mst_haddr,
    output logic [1:0]          ahb_mst_htrans,
    output logic                ahb_mst_hwrite,
    output logic [2:0]          ahb_mst_hsize,
    output logic [2:0]          ahb_mst_hburst,
    output logic [3:0]          ahb_mst_hprot,
    output logic                ahb_mst_hlock,
    output logic [31:0]         ahb_mst_hwdata,
    input  logic [31:0]         ahb_mst_hrdata,
    input  logic                ahb_mst_hready,
    input  logic [1:0]          ahb_mst_hresp
);

    localparam int IW = idx_w(NPORTS);

    arb_state_t        state_q, state_d;
    hdr_t              hold       [NPORTS];
    logic [31:0]       hold_wdata [NPORTS];
    logic [31:0]       rdata_q    [NPORTS];
    logic [1:0]        resp_q     [NPORTS];
    logic [NPORTS-1:0] pend, wcap, accept, arb_grant;
    logic [IW-1:0]     gnt_q, arb_idx, lock_owner;
    logic              lock_valid, arb_any, owner_rdy;
    logic              load_addr, load_wdata, cap_resp, done;
    logic              unused_hburst;

    // Bursts are flattened into singles, so the requested burst type is never looked at.
    assign unused_hburst  = ^ahb_mmst_hburst;
    assign ahb_mst_hburst = tSINGLE;
    assign arb_any        = |arb_grant;
    assign owner_rdy      = (state_q == S_RESP) || (state_q == S_ERR2);

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        assign accept[k] = ((ahb_mmst_htrans[2*k +: 2] == tNONSEQ) ||
                            (ahb_mmst_htrans[2*k +: 2] == tSEQ)) && ahb_mmst_hready[k];
        assign ahb_mmst_hready[k]         = !pend[k] || (owner_rdy && gnt_q == IW'(k));
        assign ahb_mmst_hrdata[32*k +: 32] = rdata_q[k];
        assign ahb_mmst_hresp[2*k +: 2]    = resp_q[k];
    end

    ahb_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
        .hclk       (hclk),
        .resetn     (resetn),
        .req        (pend),
        .lock_valid (lock_valid),
        .lock_owner (lock_owner),
        .update     (load_addr),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_addr  = 1'b0;
        load_wdata = 1'b0;
        cap_resp   = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: if (arb_any) begin
                load_addr = 1'b1;
                state_d   = S_ADDR;
            end
            S_ADDR: if (ahb_mst_hready) begin
                load_wdata = 1'b1;
                state_d    = S_DATA;
            end
            S_DATA: if (ahb_mst_hready) begin
                cap_resp = 1'b1;
                state_d  = (ahb_mst_hresp == rOKAY) ? S_RESP : S_ERR1;
            end
            S_RESP: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR1: state_d = S_ERR2;
            S_ERR2: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            ahb_mst_haddr  <= '0;
            ahb_mst_htrans <= tIDLE;
            ahb_mst_hwrite <= 1'b0;
            ahb_mst_hsize  <= '0;
            ahb_mst_hprot  <= '0;
            ahb_mst_hlock  <= 1'b0;
            ahb_mst_hwdata <= '0;
            gnt_q          <= '0;
            lock_valid     <= 1'b0;
            lock_owner     <= '0;
        end else begin
            if (load_addr) begin
                ahb_mst_haddr  <= hold[arb_idx].addr;
                ahb_mst_hwrite <= hold[arb_idx].write;
                ahb_mst_hsize  <= hold[arb_idx].size;
                ahb_mst_hprot  <= hold[arb_idx].prot;
                ahb_mst_hlock  <= hold[arb_idx].lock;
                ahb_mst_htrans <= tNONSEQ;
                gnt_q          <= arb_idx;
            end
            if (load_wdata) begin
                ahb_mst_htrans <= tIDLE;
                ahb_mst_hwdata <= hold_wdata[gnt_q];
            end
            // Lock follows the hlock of each completed owner transfer; any error drops it.
            if (state_q == S_ERR2) begin
                lock_valid <= 1'b0;
            end else if (state_q == S_RESP) begin
                lock_valid <= ahb_mst_hlock;
                lock_owner <= gnt_q;
            end
        end
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
            wcap <= '0;
            for (int k = 0; k < NPORTS; k++) begin
                hold[k]       <= '0;
                hold_wdata[k] <= '0;
                rdata_q[k]    <= '0;
                resp_q[k]     <= rOKAY;
            end
        end else begin
            wcap <= accept;
            for (int k = 0; k < NPORTS; k++) begin
                // A new accept in the completion cycle keeps the port pending.
                if (accept[k]) begin
                    hold[k] <= '{addr:  ahb_mmst_haddr[32*k +: 32],
                                 write: ahb_mmst_hwrite[k],
                                 size:  ahb_mmst_hsize[3*k +: 3],
                                 prot:  ahb_mmst_hprot[4*k +: 4],
                                 lock:  ahb_mmst_hlock[k]};
                    pend[k] <= 1'b1;
                end else if (done && gnt_q == IW'(k)) begin
                    pend[k] <= 1'b0;
                end
                if (wcap[k]) begin
                    hold_wdata[k] <= ahb_mmst_hwdata[32*k +: 32];
                end
                if (cap_resp && gnt_q == IW'(k)) begin
                    rdata_q[k] <= ahb_mst_hrdata;
                    resp_q[k]  <= (ahb_mst_hresp == rOKAY) ? rOKAY : rERROR;
                end else if (state_q == S_ERR2 && gnt_q == IW'(k)) begin
                    resp_q[k] <= rOKAY;
                end
            end
        end
    end

endmodule
